list_fetch_arbiter: RTL and testbench

Round-robin arbiter that shares one upstream list-reader AXI4-Stream among N list cache consumers. Each consumer raises a request when its cache needs refilling. The arbiter grants one consumer and issues a fetch command carrying that consumer's list index. It then routes exactly BL returning beats to that consumer before granting the next. It sits between the DMA/list reader and the bank of list cache instances.

---
 rtl/list_fetch_arbiter_if.sv | 32 +++
 rtl/list_fetch_arbiter.sv | 146 ++++++++++++++
 tb/tb_list_fetch_arbiter.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/list_fetch_arbiter_if.sv
// list_fetch_arbiter_if: bundles the request/grant, fetch-command, upstream
// stream and per-consumer stream signals of the list fetch arbiter.
// master = arbiter side, slave = environment (reader + cache bank) side.
interface list_fetch_arbiter_if #(
    parameter int N   = 4,
    parameter int DBW = 256
);
    logic [N-1:0]   req;
    logic [N-1:0]   gnt;
    logic           cmd_valid;
    logic           cmd_ready;
    logic [3:0]     cmd_dest;
    logic [DBW-1:0] s_tdata;
    logic           s_tvalid;
    logic           s_tready;
    logic [3:0]     s_tdest;
    logic           s_tlast;
    logic [DBW-1:0] m_tdata;
    logic [N-1:0]   m_tvalid;
    logic [N-1:0]   m_tready;
    logic           err;

    modport master (
        input  req, cmd_ready, s_tdata, s_tvalid, s_tdest, s_tlast, m_tready,
        output gnt, cmd_valid, cmd_dest, s_tready, m_tdata, m_tvalid, err
    );

    modport slave (
        output req, cmd_ready, s_tdata, s_tvalid, s_tdest, s_tlast, m_tready,
        input  gnt, cmd_valid, cmd_dest, s_tready, m_tdata, m_tvalid, err
    );
endinterface

// File: rtl/list_fetch_arbiter.sv
// list_fetch_arbiter: round-robin arbiter sharing one upstream list-reader
// stream among N list cache consumers. One grant = one fetch command plus
// exactly BL routed data beats.
// Optional feature macro: LIST_ARB_DEST_CHECK_EN (beat TDEST/TLAST checking,
// sticky error flag, draining of misrouted beats).
module list_fetch_arbiter #(
    parameter int N   = 4,
    parameter int DBW = 256,
    parameter int BL  = 2,
    localparam int IW = $clog2(N)
) (
    input  logic                   i_aclk,
    input  logic                   i_aresetn,   // active-high despite the name
    list_fetch_arbiter_if.master   bus
);
    localparam int CW = $clog2(BL + 1);

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA} state_t;

    state_t        r_state;
    logic [IW-1:0] r_last;
    logic [IW-1:0] r_cur;
    logic [CW-1:0] r_cnt;
    logic [N-1:0]  r_gnt;
    logic          r_cmd_valid;
    logic [3:0]    r_cmd_dest;

    logic [IW-1:0] w_pick;
    logic          w_any;
    logic          w_in_data;
    logic          w_dest_bad;
    logic          w_s_tready;
    logic [N-1:0]  w_m_tvalid;
    logic          w_beat;
    logic          w_cnt_last;

    // Round-robin pick: scan farthest to nearest from last+1 so the nearest
    // pending requester overwrites and wins.
    always_comb begin
        int sum;
        w_any  = 1'b0;
        w_pick = '0;
        for (int i = N; i >= 1; i--) begin
            sum = int'(r_last) + i;
            if (sum >= N) sum = sum - N;
            if (bus.req[sum]) begin
                w_any  = 1'b1;
                w_pick = IW'(sum);
            end
        end
    end

    assign w_in_data  = (r_state == S_DATA);
    assign w_cnt_last = (r_cnt == CW'(BL - 1));

`ifdef LIST_ARB_DEST_CHECK_EN
    assign w_dest_bad = w_in_data && (bus.s_tdest != 4'(r_cur));
`else
    assign w_dest_bad = 1'b0;
    wire   w_unused_ok = ^{bus.s_tdest, bus.s_tlast};
`endif

    // Data routing: pass-through to the granted consumer only while in DATA;
    // misrouted beats are hidden from every consumer and drained.
    always_comb begin
        w_s_tready = 1'b0;
        w_m_tvalid = '0;
        if (w_in_data) begin
            if (w_dest_bad) begin
                w_s_tready = 1'b1;
            end else begin
                w_s_tready        = bus.m_tready[r_cur];
                w_m_tvalid[r_cur] = bus.s_tvalid;
            end
        end
    end

    assign w_beat = w_in_data && bus.s_tvalid && w_s_tready;

    // Arbitration FSM with registered grant and command outputs.
    always_ff @(posedge i_aclk) begin
        if (i_aresetn) begin
            r_state     <= S_IDLE;
            r_last      <= IW'(N - 1);
            r_cur       <= '0;
            r_cnt       <= '0;
            r_gnt       <= '0;
            r_cmd_valid <= 1'b0;
            r_cmd_dest  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_cur       <= w_pick;
                        r_gnt       <= N'(1) << w_pick;
                        r_cmd_valid <= 1'b1;
                        r_cmd_dest  <= 4'(w_pick);
                        r_state     <= S_CMD;
                    end
                end
                S_CMD: begin
                    if (bus.cmd_ready) begin
                        r_cmd_valid <= 1'b0;
                        r_cnt       <= '0;
                        r_state     <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_beat) begin
                        r_cnt <= r_cnt + CW'(1);
                        if (w_cnt_last) begin
                            r_last  <= r_cur;
                            r_gnt   <= '0;
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef LIST_ARB_DEST_CHECK_EN
    logic r_err;

    // Sticky protocol error: wrong destination or TLAST out of place.
    always_ff @(posedge i_aclk) begin
        if (i_aresetn) begin
            r_err <= 1'b0;
        end else if (w_beat && (w_dest_bad || (bus.s_tlast != w_cnt_last))) begin
            r_err <= 1'b1;
        end
    end

    assign bus.err = r_err;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.gnt       = r_gnt;
    assign bus.cmd_valid = r_cmd_valid;
    assign bus.cmd_dest  = r_cmd_dest;
    assign bus.s_tready  = w_s_tready;
    assign bus.m_tvalid  = w_m_tvalid;
    assign bus.m_tdata   = bus.s_tdata;
endmodule

// File: tb/tb_list_fetch_arbiter.sv
// tb_list_fetch_arbiter: directed-vector bench for list_fetch_arbiter
// (N=4, DBW=256, BL=2). Honours LIST_ARB_DEST_CHECK_EN when defined.
module tb_list_fetch_arbiter;
    localparam int N   = 4;
    localparam int DBW = 256;
    localparam int BL  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    list_fetch_arbiter_if #(.N(N), .DBW(DBW)) bus ();

    list_fetch_arbiter #(.N(N), .DBW(DBW), .BL(BL)) u_dut (
        .i_aclk   (clk),
        .i_aresetn(rst),
        .bus      (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Full grant cycle starting in IDLE: arbitrate, command handshake, BL beats.
    task automatic burst(input int idx, input string tag);
        logic [63:0] oh;
        oh = 64'd1 << idx;
        step();
        #1;
        chk({tag, "_gnt"},      64'(bus.gnt), oh);
        chk({tag, "_cmdv"},     64'(bus.cmd_valid), 64'd1);
        chk({tag, "_cmddest"},  64'(bus.cmd_dest), 64'(idx));
        step();
        bus.s_tvalid = 1'b1;
        bus.s_tdest  = 4'(idx);
        bus.s_tlast  = 1'b0;
        bus.s_tdata  = {8{32'hC0DE_0000 + 32'(idx)}};
        #1;
        chk({tag, "_cmdv_off"}, 64'(bus.cmd_valid), 64'd0);
        chk({tag, "_mtv1"},     64'(bus.m_tvalid), oh);
        chk({tag, "_srdy1"},    64'(bus.s_tready), 64'd1);
        chk({tag, "_mdata"},    bus.m_tdata[63:0], {32'hC0DE_0000 + 32'(idx), 32'hC0DE_0000 + 32'(idx)});
        step();
        bus.s_tlast = 1'b1;
        #1;
        chk({tag, "_mtv2"},     64'(bus.m_tvalid), oh);
        step();
        bus.s_tvalid = 1'b0;
        bus.s_tlast  = 1'b0;
        #1;
        chk({tag, "_gnt_done"}, 64'(bus.gnt), 64'd0);
    endtask

    initial begin
        bus.req       = '0;
        bus.cmd_ready = 1'b1;
        bus.s_tdata   = '0;
        bus.s_tvalid  = 1'b0;
        bus.s_tdest   = '0;
        bus.s_tlast   = 1'b0;
        bus.m_tready  = '1;

        // Reset values, with an upstream beat offered in IDLE
        do_reset();
        bus.s_tvalid = 1'b1;
        #1;
        chk("rst_gnt",    64'(bus.gnt), 64'd0);
        chk("rst_cmdv",   64'(bus.cmd_valid), 64'd0);
        chk("rst_cmddst", 64'(bus.cmd_dest), 64'd0);
        chk("rst_srdy",   64'(bus.s_tready), 64'd0);
        chk("rst_mtv",    64'(bus.m_tvalid), 64'd0);
        chk("rst_err",    64'(bus.err), 64'd0);
        bus.s_tvalid = 1'b0;

        // Single requester
        bus.req = 4'b0001;
        burst(0, "single");
        bus.req = 4'b0000;
        step();
        chk("single_idle_gnt", 64'(bus.gnt), 64'd0);

        // Round-robin from reset: 0,1,2,3 then 1001 after 3 -> 0
        do_reset();
        bus.req = 4'b1111;
        burst(0, "rr0");
        burst(1, "rr1");
        burst(2, "rr2");
        burst(3, "rr3");
        bus.req = 4'b1001;
        burst(0, "rr_wrap");

        // Backpressure: grant 1, stall after first beat for 3 cycles
        bus.req = 4'b0010;
        step();
        bus.req = 4'b0000;
        #1;
        chk("bp_gnt", 64'(bus.gnt), 64'b0010);
        step();
        bus.s_tvalid = 1'b1;
        bus.s_tdest  = 4'd1;
        step();                                 // beat 1
        bus.m_tready = 4'b1101;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp_srdy", 64'(bus.s_tready), 64'd0);
            chk("bp_mtv",  64'(bus.m_tvalid), 64'b0010);
            step();
            chk("bp_gnt_hold", 64'(bus.gnt), 64'b0010);
        end
        bus.m_tready = 4'b1111;
        bus.s_tlast  = 1'b1;
        #1;
        chk("bp_srdy_back", 64'(bus.s_tready), 64'd1);
        step();                                 // beat 2
        bus.s_tvalid = 1'b0;
        bus.s_tlast  = 1'b0;
        #1;
        chk("bp_done_gnt", 64'(bus.gnt), 64'd0);

        // CMD stall: CMD_READY low for 5 cycles
        bus.cmd_ready = 1'b0;
        bus.req       = 4'b0100;
        step();
        bus.req      = 4'b0000;
        bus.s_tvalid = 1'b1;
        bus.s_tdest  = 4'd2;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("stall_cmdv", 64'(bus.cmd_valid), 64'd1);
            chk("stall_dest", 64'(bus.cmd_dest), 64'd2);
            chk("stall_srdy", 64'(bus.s_tready), 64'd0);
            step();
        end
        bus.cmd_ready = 1'b1;
        step();                                 // handshake
        #1;
        chk("stall_data_mtv", 64'(bus.m_tvalid), 64'b0100);
        step();                                 // beat 1
        bus.s_tlast = 1'b1;
        step();                                 // beat 2
        bus.s_tvalid = 1'b0;
        bus.s_tlast  = 1'b0;
        #1;
        chk("stall_done_gnt", 64'(bus.gnt), 64'd0);
        chk("stall_err",      64'(bus.err), 64'd0);

        // Reset mid-DATA after one beat
        bus.req = 4'b1000;
        step();
        bus.req = 4'b0000;
        step();
        bus.s_tvalid = 1'b1;
        bus.s_tdest  = 4'd3;
        step();                                 // beat 1
        rst = 1'b1;
        step();
        #1;
        chk("mrst_gnt",  64'(bus.gnt), 64'd0);
        chk("mrst_cmdv", 64'(bus.cmd_valid), 64'd0);
        chk("mrst_srdy", 64'(bus.s_tready), 64'd0);
        chk("mrst_mtv",  64'(bus.m_tvalid), 64'd0);
        rst          = 1'b0;
        bus.s_tvalid = 1'b0;
        bus.req      = 4'b0100;
        burst(2, "mrst_next");
        bus.req = 4'b0000;

        // Misrouted beat: TDEST=3 while cur=1
        bus.req = 4'b0010;
        step();
        bus.req = 4'b0000;
        step();
        bus.s_tvalid = 1'b1;
        bus.s_tdest  = 4'd3;
        #1;
`ifdef LIST_ARB_DEST_CHECK_EN
        chk("dest_mtv",  64'(bus.m_tvalid), 64'd0);
        chk("dest_srdy", 64'(bus.s_tready), 64'd1);
`else
        chk("dest_mtv",  64'(bus.m_tvalid), 64'b0010);
        chk("dest_srdy", 64'(bus.s_tready), 64'd1);
`endif
        step();                                 // misrouted beat consumed
        bus.s_tdest = 4'd1;
        bus.s_tlast = 1'b1;
        #1;
`ifdef LIST_ARB_DEST_CHECK_EN
        chk("dest_err", 64'(bus.err), 64'd1);
`else
        chk("dest_err", 64'(bus.err), 64'd0);
`endif
        chk("dest_gnt_mid", 64'(bus.gnt), 64'b0010);
        step();                                 // second beat ends burst
        bus.s_tvalid = 1'b0;
        bus.s_tlast  = 1'b0;
        #1;
        chk("dest_done_gnt", 64'(bus.gnt), 64'd0);
`ifdef LIST_ARB_DEST_CHECK_EN
        chk("dest_err_sticky", 64'(bus.err), 64'd1);
`else
        chk("dest_err_sticky", 64'(bus.err), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
